// File: rtl/cache_line_fill.sv
// Line fill unit: fetches four CPU-word beats on a miss, writes the assembled line, returns the missed word.
// Optional feature macro: CACHE_CRITICAL_WORD_FIRST_EN (wrapped burst from the missed word, early CPU return).
module cache_line_fill #(
  parameter int unsigned CPU_DATA_SIZE    = 32,
  parameter int unsigned RAM_DATA_SIZE    = 128,
  parameter int unsigned ADDR_SIZE        = 32,
  parameter int unsigned ADDR_OFFSET_SIZE = 4
) (
  input  logic                     IN_CLK,
  input  logic                     IN_RST,
  input  logic                     IN_MISS_REQ,
  input  logic [ADDR_SIZE-1:0]     IN_MISS_ADDR,
  output logic                     OUT_BUSY,
  output logic                     OUT_MEM_RD_REQ,
  output logic [ADDR_SIZE-1:0]     OUT_MEM_ADDR,
  input  logic                     IN_MEM_RD_GNT,
  input  logic                     IN_MEM_RD_VALID,
  input  logic [CPU_DATA_SIZE-1:0] IN_MEM_RD_DATA,
  output logic                     OUT_LINE_WE,
  output logic [ADDR_SIZE-1:0]     OUT_LINE_ADDR,
  output logic [RAM_DATA_SIZE-1:0] OUT_LINE_DATA,
  output logic                     OUT_CPU_VALID,
  output logic [CPU_DATA_SIZE-1:0] OUT_CPU_DATA
);

  localparam int unsigned WORDS = 4;
  localparam int unsigned IDX_W = 2;
  localparam logic [ADDR_SIZE-1:0] LINE_MASK =
    ~ADDR_SIZE'((64'd1 << ADDR_OFFSET_SIZE) - 64'd1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BEATS, S_WRITE} state_t;

  state_t                     r_state;
  state_t                     w_next_state;
  logic [IDX_W-1:0]           r_start;
  logic [IDX_W-1:0]           r_cnt;
  logic [ADDR_SIZE-1:0]       r_miss_base;
  logic                       r_busy;
  logic                       r_mem_rd_req;
  logic [ADDR_SIZE-1:0]       r_mem_addr;
  logic                       r_line_we;
  logic [ADDR_SIZE-1:0]       r_line_addr;
  logic [RAM_DATA_SIZE-1:0]   r_line_data;
  logic                       r_cpu_valid;
  logic [CPU_DATA_SIZE-1:0]   r_cpu_data;

  logic                       w_accept;
  logic                       w_beat;
  logic [IDX_W-1:0]           w_miss_idx;
  logic [IDX_W-1:0]           w_start_new;
  logic [IDX_W-1:0]           w_slot;
  logic [RAM_DATA_SIZE-1:0]   w_line_next;

  assign w_accept   = (r_state == S_IDLE) && IN_MISS_REQ;
  assign w_beat     = (r_state == S_BEATS) && IN_MEM_RD_VALID;
  assign w_miss_idx = IN_MISS_ADDR[ADDR_OFFSET_SIZE-1 -: IDX_W];
  assign w_slot     = r_start + r_cnt;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  assign w_start_new = w_miss_idx;
`else
  logic [IDX_W-1:0]         r_idx;
  logic [CPU_DATA_SIZE-1:0] w_cpu_word;
  assign w_start_new = '0;
`endif

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (IN_MISS_REQ) w_next_state = S_REQ;
      S_REQ:   if (IN_MEM_RD_GNT) w_next_state = S_BEATS;
      S_BEATS: if (IN_MEM_RD_VALID && (r_cnt == IDX_W'(WORDS - 1))) w_next_state = S_WRITE;
      S_WRITE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Line image with the current beat merged into its wrapped slot
  always_comb begin
    w_line_next = r_line_data;
    for (int k = 0; k < int'(WORDS); k++) begin
      if (w_slot == IDX_W'(k)) w_line_next[k*CPU_DATA_SIZE +: CPU_DATA_SIZE] = IN_MEM_RD_DATA;
    end
  end

`ifndef CACHE_CRITICAL_WORD_FIRST_EN
  always_comb begin
    w_cpu_word = '0;
    for (int k = 0; k < int'(WORDS); k++) begin
      if (r_idx == IDX_W'(k)) w_cpu_word = w_line_next[k*CPU_DATA_SIZE +: CPU_DATA_SIZE];
    end
  end
`endif

  always_ff @(posedge IN_CLK) begin
    if (IN_RST) begin
      r_state      <= S_IDLE;
      r_start      <= '0;
      r_cnt        <= '0;
      r_miss_base  <= '0;
      r_busy       <= 1'b0;
      r_mem_rd_req <= 1'b0;
      r_mem_addr   <= '0;
      r_line_we    <= 1'b0;
      r_line_addr  <= '0;
      r_line_data  <= '0;
      r_cpu_valid  <= 1'b0;
      r_cpu_data   <= '0;
`ifndef CACHE_CRITICAL_WORD_FIRST_EN
      r_idx        <= '0;
`endif
    end else begin
      r_state      <= w_next_state;
      r_busy       <= (w_next_state != S_IDLE);
      r_mem_rd_req <= (w_next_state == S_REQ);
      r_line_we    <= (w_next_state == S_WRITE);
      r_cpu_valid  <= 1'b0;
      if (w_accept) begin
        r_miss_base <= IN_MISS_ADDR & LINE_MASK;
        r_start     <= w_start_new;
        r_mem_addr  <= (IN_MISS_ADDR & LINE_MASK) |
                       (ADDR_SIZE'(w_start_new) << (ADDR_OFFSET_SIZE - 2));
`ifndef CACHE_CRITICAL_WORD_FIRST_EN
        r_idx       <= w_miss_idx;
`endif
      end
      if ((r_state == S_REQ) && IN_MEM_RD_GNT) r_cnt <= '0;
      if (w_beat) begin
        r_line_data <= w_line_next;
        r_cnt       <= r_cnt + IDX_W'(1);
      end
      if ((r_state == S_BEATS) && (w_next_state == S_WRITE)) r_line_addr <= r_miss_base;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
      // Missed word is the first beat of the wrapped burst
      if (w_beat && (r_cnt == '0)) begin
        r_cpu_valid <= 1'b1;
        r_cpu_data  <= IN_MEM_RD_DATA;
      end
`else
      if (w_beat && (r_cnt == IDX_W'(WORDS - 1))) begin
        r_cpu_valid <= 1'b1;
        r_cpu_data  <= w_cpu_word;
      end
`endif
    end
  end

  assign OUT_BUSY       = r_busy;
  assign OUT_MEM_RD_REQ = r_mem_rd_req;
  assign OUT_MEM_ADDR   = r_mem_addr;
  assign OUT_LINE_WE    = r_line_we;
  assign OUT_LINE_ADDR  = r_line_addr;
  assign OUT_LINE_DATA  = r_line_data;
  assign OUT_CPU_VALID  = r_cpu_valid;
  assign OUT_CPU_DATA   = r_cpu_data;

endmodule

// File: tb/tb_cache_line_fill.sv
// Bench for cache_line_fill: directed and randomized fills checked against a line-level reference model.
module tb_cache_line_fill;

`ifdef CACHE_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         miss_req = 1'b0;
  logic [31:0]  miss_addr = '0;
  logic         busy;
  logic         mem_rd_req;
  logic [31:0]  mem_addr;
  logic         gnt = 1'b0;
  logic         valid = 1'b0;
  logic [31:0]  rdata = '0;
  logic         line_we;
  logic [31:0]  line_addr;
  logic [127:0] line_data;
  logic         cpu_valid;
  logic [31:0]  cpu_data;

  int n_cmp = 0;
  int n_err = 0;

  cache_line_fill dut (
    .IN_CLK(clk), .IN_RST(rst),
    .IN_MISS_REQ(miss_req), .IN_MISS_ADDR(miss_addr),
    .OUT_BUSY(busy), .OUT_MEM_RD_REQ(mem_rd_req), .OUT_MEM_ADDR(mem_addr),
    .IN_MEM_RD_GNT(gnt), .IN_MEM_RD_VALID(valid), .IN_MEM_RD_DATA(rdata),
    .OUT_LINE_WE(line_we), .OUT_LINE_ADDR(line_addr), .OUT_LINE_DATA(line_data),
    .OUT_CPU_VALID(cpu_valid), .OUT_CPU_DATA(cpu_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // busy / rd_req / line_we / cpu_valid as one vector
  task automatic chk_ctl(input string tag, input bit b, input bit r, input bit w, input bit c);
    chk(tag, {124'd0, busy, mem_rd_req, line_we, cpu_valid}, {124'd0, b, r, w, c});
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {124'd0, busy, mem_rd_req, line_we, cpu_valid}, '0);
    chk({tag, "_addrs"}, {64'd0, mem_addr, line_addr}, '0);
    chk({tag, "_line"}, line_data, '0);
    chk({tag, "_cpu"}, {96'd0, cpu_data}, '0);
  endtask

  // One miss: grant after gdelay, random valid gaps if gaps set, optional noise
  // (stray valid/miss), optional reset after abort_after beats (4 = no abort).
  task automatic do_fill(input logic [31:0] addr, input int gdelay, input bit gaps,
                         input int abort_after, input bit noise);
    logic [31:0]  beats [4];
    logic [127:0] exp_line;
    logic [31:0]  exp_maddr;
    logic [31:0]  word;
    int idx, start, got;
    bit v, wr, cv;
    idx       = int'((addr >> 2) & 32'd3);
    start     = CWF ? idx : 0;
    exp_maddr = (addr & ~32'hF) | (32'(start) << 2);

    miss_req = 1'b1; miss_addr = addr;
    tick();
    miss_req = 1'b0; miss_addr = $urandom;
    chk_ctl("req_enter", 1, 1, 0, 0);
    chk("mem_addr", {96'd0, mem_addr}, {96'd0, exp_maddr});
    for (int d = 0; d < gdelay; d++) begin
      gnt = 1'b0; valid = noise ? 1'($urandom) : 1'b0; rdata = $urandom;
      tick();
      chk_ctl("req_wait", 1, 1, 0, 0);
      chk("mem_addr_hold", {96'd0, mem_addr}, {96'd0, exp_maddr});
    end
    gnt = 1'b1; valid = noise; rdata = $urandom;
    tick();
    gnt = 1'b0;
    chk_ctl("granted", 1, 0, 0, 0);

    got = 0;
    while (got < 4) begin
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      valid = v; rdata = $urandom; miss_req = noise ? 1'($urandom) : 1'b0;
      if (v) beats[got] = rdata;
      tick();
      if (v) got++;
      wr = v && (got == 4);
      cv = CWF ? (v && got == 1) : wr;
      chk_ctl("beat", 1, 0, wr, cv);
      if (CWF && cv) chk("cpu_early", {96'd0, cpu_data}, {96'd0, beats[0]});
      if (got == abort_after && got < 4) begin
        rst = 1'b1; valid = 1'b0; miss_req = 1'b0;
        tick();
        rst = 1'b0;
        chk_zero("abort");
        tick();
        chk_zero("abort_idle");
        return;
      end
    end

    exp_line = '0;
    for (int i = 0; i < 4; i++) exp_line[((start + i) % 4) * 32 +: 32] = beats[i];
    chk("line_data", line_data, exp_line);
    chk("line_addr", {96'd0, line_addr}, {96'd0, addr & ~32'hF});
    if (!CWF) begin
      word = exp_line[idx*32 +: 32];
      chk("cpu_late", {96'd0, cpu_data}, {96'd0, word});
    end

    valid = noise; rdata = $urandom; miss_req = noise;
    tick();
    miss_req = 1'b0;
    chk_ctl("post_write", 0, 0, 0, 0);
    valid = noise; rdata = $urandom;
    tick();
    valid = 1'b0;
    chk_ctl("idle_stray", 0, 0, 0, 0);
    chk("line_hold", line_data, exp_line);
  endtask

  initial begin
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_zero("reset");

    do_fill(32'h0000_1008, 0, 1'b0, 4, 1'b0);
    do_fill(32'h0000_5000 | 32'($urandom_range(0, 15)), 5, 1'b1, 4, 1'b1);
    do_fill(32'h0000_4004, 0, 1'b1, 4, 1'b1);
    do_fill(32'h1234_5678, 1, 1'b0, 2, 1'b0);
    do_fill(32'h0000_2004, 0, 1'b0, 4, 1'b0);
    do_fill(32'h0000_300C, 0, 1'b0, 4, 1'b0);
    do_fill(32'h0000_6008, 2, 1'b0, 4, 1'b1);

    for (int n = 0; n < 25; n++) begin
      do_fill($urandom, $urandom_range(0, 4), 1'($urandom), (n % 7 == 3) ? $urandom_range(1, 3) : 4,
              1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
